// File: rtl/sirv_plic_icb_arb.sv
// 2:1 ICB arbiter in front of the PLIC slave port: round-robin grant, in-order ID FIFO for response routing.
// Build option: define SIRV_PLIC_ICB_ARB_FIXED_PRIO_EN for fixed priority (m0 wins ties).
module sirv_plic_icb_arb #(
  parameter int AW         = 32,
  parameter int DW         = 32,
  parameter int OUTS_DEPTH = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          m0_icb_cmd_valid,
  output logic          m0_icb_cmd_ready,
  input  logic [AW-1:0] m0_icb_cmd_addr,
  input  logic          m0_icb_cmd_read,
  input  logic [DW-1:0] m0_icb_cmd_wdata,
  output logic          m0_icb_rsp_valid,
  input  logic          m0_icb_rsp_ready,
  output logic [DW-1:0] m0_icb_rsp_rdata,
  input  logic          m1_icb_cmd_valid,
  output logic          m1_icb_cmd_ready,
  input  logic [AW-1:0] m1_icb_cmd_addr,
  input  logic          m1_icb_cmd_read,
  input  logic [DW-1:0] m1_icb_cmd_wdata,
  output logic          m1_icb_rsp_valid,
  input  logic          m1_icb_rsp_ready,
  output logic [DW-1:0] m1_icb_rsp_rdata,
  output logic          s_icb_cmd_valid,
  input  logic          s_icb_cmd_ready,
  output logic [AW-1:0] s_icb_cmd_addr,
  output logic          s_icb_cmd_read,
  output logic [DW-1:0] s_icb_cmd_wdata,
  input  logic          s_icb_rsp_valid,
  output logic          s_icb_rsp_ready,
  input  logic [DW-1:0] s_icb_rsp_rdata
);

  // Handshake: a beat transfers on a channel in the cycle where valid and ready
  // are both 1; a master keeps valid and payload stable until that happens.

  localparam int PW = (OUTS_DEPTH > 1) ? $clog2(OUTS_DEPTH) : 1;
  localparam int CW = $clog2(OUTS_DEPTH + 1);

  logic [CW-1:0]         cnt_q, cnt_d;
  logic [PW-1:0]         wptr_q, wptr_d, rptr_q, rptr_d;
  logic [OUTS_DEPTH-1:0] fifo_q, fifo_d;
  logic                  last_gnt_q, last_gnt_d;
  logic                  lock_q, lock_d;
  logic                  lock_id_q, lock_id_d;

  logic       full, empty, gnt, head, cmd_hsk, rsp_hsk;
  logic [1:0] req;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(OUTS_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    full  = (cnt_q == CW'(OUTS_DEPTH));
    empty = (cnt_q == '0);
    req   = {m1_icb_cmd_valid, m0_icb_cmd_valid} & {2{~full}};

    // A command offered but not yet accepted keeps its grant.
    if (lock_q) begin
      gnt = lock_id_q;
    end else if (req == 2'b11) begin
`ifdef SIRV_PLIC_ICB_ARB_FIXED_PRIO_EN
      gnt = 1'b0;
`else
      gnt = ~last_gnt_q;
`endif
    end else begin
      gnt = req[1];
    end

    s_icb_cmd_valid  = req[gnt];
    s_icb_cmd_addr   = gnt ? m1_icb_cmd_addr  : m0_icb_cmd_addr;
    s_icb_cmd_read   = gnt ? m1_icb_cmd_read  : m0_icb_cmd_read;
    s_icb_cmd_wdata  = gnt ? m1_icb_cmd_wdata : m0_icb_cmd_wdata;
    m0_icb_cmd_ready = s_icb_cmd_valid & s_icb_cmd_ready & ~gnt;
    m1_icb_cmd_ready = s_icb_cmd_valid & s_icb_cmd_ready &  gnt;
    cmd_hsk          = s_icb_cmd_valid & s_icb_cmd_ready;

    head             = fifo_q[rptr_q];
    m0_icb_rsp_valid = s_icb_rsp_valid & ~empty & ~head;
    m1_icb_rsp_valid = s_icb_rsp_valid & ~empty &  head;
    m0_icb_rsp_rdata = s_icb_rsp_rdata;
    m1_icb_rsp_rdata = s_icb_rsp_rdata;
    s_icb_rsp_ready  = ~empty & (head ? m1_icb_rsp_ready : m0_icb_rsp_ready);
    rsp_hsk          = s_icb_rsp_valid & s_icb_rsp_ready;

    fifo_d     = fifo_q;
    wptr_d     = wptr_q;
    rptr_d     = rptr_q;
    last_gnt_d = last_gnt_q;
    if (cmd_hsk) begin
      fifo_d[wptr_q] = gnt;
      wptr_d         = ptr_inc(wptr_q);
      last_gnt_d     = gnt;
    end
    if (rsp_hsk) begin
      rptr_d = ptr_inc(rptr_q);
    end

    unique case ({cmd_hsk, rsp_hsk})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase

    lock_id_d = lock_q ? lock_id_q : gnt;
    if (cmd_hsk) begin
      lock_d = 1'b0;
    end else if (s_icb_cmd_valid) begin
      lock_d = 1'b1;
    end else begin
      lock_d = lock_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q      <= '0;
      wptr_q     <= '0;
      rptr_q     <= '0;
      fifo_q     <= '0;
      last_gnt_q <= 1'b1;
      lock_q     <= 1'b0;
      lock_id_q  <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      fifo_q     <= fifo_d;
      last_gnt_q <= last_gnt_d;
      lock_q     <= lock_d;
      lock_id_q  <= lock_id_d;
    end
  end

endmodule
